branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised EX-stage branch resolution unit for the pipelined processor. It generalises the single-condition BNE path to six compare modes plus unconditional jump, computes the word-addressed branch target, and issues a one-cycle PC redirect. It drives a counted flush of the younger pipeline stages and keeps saturating branch statistics for bench readback.

## Interface
- DataWidth, 16, width of compared operands
- PCWidth, 16, width of word-addressed PC
- OffsetBits, 6, width of signed branch offset (in instructions)
- FlushDepth, 2, younger stages squashed on a taken branch (≥1)
- CountWidth, 16, width of statistics counters

- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- br_valid  input  1  branch/jump in EX this cycle
- br_mode  input  3  000 BEQ, 001 BNE, 010 BLT (signed), 011 BGE (signed), 100 BLTU, 101 BGEU, 110 JMP (always), 111 reserved (never taken)
- op_a, op_b  input  DataWidth  forwarded source operands
- pc_ex  input  PCWidth  PC of the branch instruction
- offset  input  OffsetBits  signed offset, two's complement
- stall  input  1  pipeline stall; holds unit state
- clear_stats  input  1  synchronous clear of counters
- redirect  output  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  output  PCWidth  branch target
- flush  output  1  squash younger stages
- busy  output  1  high while in FLUSH
- branch_count  output  CountWidth  accepted branches, saturating
- taken_count  output  CountWidth  taken branches, saturating

## Operation
- Accept: br_valid=1, stall=0, state IDLE. br_valid is ignored while stall=1 or in FLUSH, because those instructions are being squashed.
- Condition: evaluated on op_a/op_b per br_mode. Signed modes use two's complement over DataWidth.
- Target: redirect_pc = pc_ex + 1 + sign_extend(offset), modulo 2^PCWidth, so wrap-around is silent. With offset +1, exactly one instruction is skipped.
- FSM IDLE: accepted and taken → redirect pulse, flush=1, load flush counter with FlushDepth, go FLUSH. Accepted and not taken → stay IDLE, no redirect.
- FSM FLUSH: counter decrements each non-stalled cycle. flush and busy stay high. At counter=1 with stall=0 → IDLE next cycle.
- Stall in FLUSH: counter frozen, flush held high.
- Counters: branch_count increments on every accept, including mode 111. taken_count increments on taken accepts. Both hold at all-ones.
- clear_stats=1 zeroes both counters next edge. Clear wins over a simultaneous increment.
- Reset (RST=0, any time, including mid-flush): state IDLE, counter 0. redirect=0, redirect_pc=0, flush=0, busy=0, branch_count=0, taken_count=0 immediately, with no clock needed.

## Timing
- All outputs are registered. Accept at edge T → redirect, redirect_pc, flush, busy and counters are valid after edge T+1.
- redirect is high exactly one cycle, even if stall rises in that cycle. redirect_pc holds its last target until the next taken branch.
- flush is high for FlushDepth non-stalled cycles, starting at T+1, plus any stalled cycles inside that window.
- The earliest next accept is the cycle after busy falls.
- Not-taken branch: zero bubbles. Taken branch: FlushDepth bubbles.

## Test plan
- BNE not taken: op_a=3, op_b=3, mode 001, pc_ex=2 → redirect stays 0, flush stays 0, branch_count=1, taken_count=0.
- BNE taken: op_a=1, op_b=0, pc_ex=4, offset=+1 → T+1: redirect=1, redirect_pc=6, flush=1 for 2 cycles, busy falls at T+3, taken_count=1. A br_valid pulse at T+1 is ignored.
- Signed vs unsigned: op_a=0xFFFF, op_b=0x0001. BLT → taken. BLTU → not taken. BGEU → taken. Mode 111 → not taken, branch_count increments.
- Wrap and negative offset: pc_ex=0xFFFF, offset=+1 → redirect_pc=0x0001. pc_ex=0x0003, offset=-4 (6'b111100) → redirect_pc=0x0000. JMP → taken regardless of operands.
- Stall mid-flush: taken branch, stall=1 for 3 cycles starting T+2 → flush high 5 cycles total, redirect still 1 cycle. Accept attempt with stall=1 → no count change.
- Saturation, clear and reset: CountWidth=2, 5 taken JMPs → both counters=3. clear_stats coincident with a 6th accept → both counters=0. RST=0 during FLUSH → all outputs 0 asynchronously. After release, the next branch behaves normally.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the EX stage and the branch resolve unit.
// The pipeline is the master. It drives the operands and the branch
// request, and it receives the redirect, the flush and the statistics.
interface branch_resolve_unit_if #(
    parameter int DataWidth  = 16,
    parameter int PCWidth    = 16,
    parameter int OffsetBits = 6,
    parameter int CountWidth = 16
);
    logic                  br_valid;
    logic [2:0]            br_mode;
    logic [DataWidth-1:0]  op_a;
    logic [DataWidth-1:0]  op_b;
    logic [PCWidth-1:0]    pc_ex;
    logic [OffsetBits-1:0] offset;
    logic                  stall;
    logic                  clear_stats;

    logic                  redirect;
    logic [PCWidth-1:0]    redirect_pc;
    logic                  flush;
    logic                  busy;
    logic [CountWidth-1:0] branch_count;
    logic [CountWidth-1:0] taken_count;

    modport master (
        output br_valid, br_mode, op_a, op_b, pc_ex, offset, stall, clear_stats,
        input  redirect, redirect_pc, flush, busy, branch_count, taken_count
    );

    modport slave (
        input  br_valid, br_mode, op_a, op_b, pc_ex, offset, stall, clear_stats,
        output redirect, redirect_pc, flush, busy, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution. The unit evaluates six compare modes and JMP,
// and it forms the word-addressed target pc+1+offset. On a taken branch it
// pulses a registered redirect and holds flush for FlushDepth non-stalled
// cycles. It also keeps saturating counts of accepted and taken branches.
// The design assumes PCWidth > OffsetBits.
module branch_resolve_unit #(
    parameter int DataWidth  = 16,
    parameter int PCWidth    = 16,
    parameter int OffsetBits = 6,
    parameter int FlushDepth = 2,
    parameter int CountWidth = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    branch_resolve_unit_if.slave   brif
);
    localparam int CntW = (FlushDepth < 2) ? 1 : $clog2(FlushDepth + 1);

    localparam logic [2:0] M_BEQ  = 3'b000;
    localparam logic [2:0] M_BNE  = 3'b001;
    localparam logic [2:0] M_BLT  = 3'b010;
    localparam logic [2:0] M_BGE  = 3'b011;
    localparam logic [2:0] M_BLTU = 3'b100;
    localparam logic [2:0] M_BGEU = 3'b101;
    localparam logic [2:0] M_JMP  = 3'b110;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  redirect_q, redirect_d;
    logic [PCWidth-1:0]    rpc_q, rpc_d;
    logic                  flush_q, flush_d;
    logic [CountWidth-1:0] bcnt_q, bcnt_d;
    logic [CountWidth-1:0] tcnt_q, tcnt_d;

    logic                  accept;
    logic                  cond;
    logic [PCWidth-1:0]    off_sx;
    logic [PCWidth-1:0]    target;

    // Branches that arrive during a stall or a flush belong to squashed
    // instructions, so the unit drops them.
    assign accept = brif.br_valid && !brif.stall && (state_q == IDLE);

    // Branch condition. The reserved mode 111 is never taken.
    always_comb begin
        cond = 1'b0;
        case (brif.br_mode)
            M_BEQ:   cond = (brif.op_a == brif.op_b);
            M_BNE:   cond = (brif.op_a != brif.op_b);
            M_BLT:   cond = ($signed(brif.op_a) <  $signed(brif.op_b));
            M_BGE:   cond = ($signed(brif.op_a) >= $signed(brif.op_b));
            M_BLTU:  cond = (brif.op_a <  brif.op_b);
            M_BGEU:  cond = (brif.op_a >= brif.op_b);
            M_JMP:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // The target wraps silently at 2^PCWidth.
    assign off_sx = {{(PCWidth - OffsetBits){brif.offset[OffsetBits-1]}}, brif.offset};
    assign target = brif.pc_ex + PCWidth'(1) + off_sx;

    // Next-state and output logic. redirect defaults to 0, so it is high for
    // one cycle only, even if a stall arrives in that cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        rpc_d      = rpc_q;
        flush_d    = flush_q;
        case (state_q)
            IDLE: begin
                if (accept && cond) begin
                    state_d    = FLUSH;
                    cnt_d      = CntW'(FlushDepth);
                    redirect_d = 1'b1;
                    rpc_d      = target;
                    flush_d    = 1'b1;
                end
            end
            FLUSH: begin
                if (!brif.stall) begin
                    if (cnt_q == CntW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                flush_d = 1'b0;
            end
        endcase
    end

    // Statistics. A clear wins over a simultaneous increment, and both
    // counters stop at all-ones.
    always_comb begin
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        if (brif.clear_stats) begin
            bcnt_d = '0;
            tcnt_d = '0;
        end else if (accept) begin
            if (bcnt_q != {CountWidth{1'b1}}) bcnt_d = bcnt_q + CountWidth'(1);
            if (cond && (tcnt_q != {CountWidth{1'b1}})) tcnt_d = tcnt_q + CountWidth'(1);
        end
    end

    // State and output registers. Reset is asynchronous and clears everything.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            rpc_q      <= '0;
            flush_q    <= 1'b0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            rpc_q      <= rpc_d;
            flush_q    <= flush_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // busy and flush cover the same window. Both come from one register.
    assign brif.redirect     = redirect_q;
    assign brif.redirect_pc  = rpc_q;
    assign brif.flush        = flush_q;
    assign brif.busy         = flush_q;
    assign brif.branch_count = bcnt_q;
    assign brif.taken_count  = tcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. CountWidth is 2 so that
// saturation can be reached quickly. Each step pushes the expected
// post-edge outputs to a scoreboard, and the bench pops and checks them
// after the edge.
module tb_branch_resolve_unit;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    branch_resolve_unit_if #(.CountWidth(2)) bus();
    branch_resolve_unit #(.CountWidth(2)) dut (.CLK(CLK), .RST(RST), .brif(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic        r;
        logic [15:0] pc;
        logic        f;
        logic [1:0]  bc;
        logic [1:0]  tc;
    } exp_t;
    exp_t sbq[$];

    task automatic chk1(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk1(e.tag, "redirect",     16'(bus.redirect),     16'(e.r));
            chk1(e.tag, "redirect_pc",  bus.redirect_pc,       e.pc);
            chk1(e.tag, "flush",        16'(bus.flush),        16'(e.f));
            chk1(e.tag, "busy",         16'(bus.busy),         16'(e.f));
            chk1(e.tag, "branch_count", 16'(bus.branch_count), 16'(e.bc));
            chk1(e.tag, "taken_count",  16'(bus.taken_count),  16'(e.tc));
        end
    endtask

    task automatic push(input string tag, input logic r, input logic [15:0] pc,
                        input logic f, input logic [1:0] bc, input logic [1:0] tc);
        exp_t e;
        e.tag = tag; e.r = r; e.pc = pc; e.f = f; e.bc = bc; e.tc = tc;
        sbq.push_back(e);
    endtask

    // Check the outputs now, with no clock edge.
    task automatic expect_now(input string tag, input logic r, input logic [15:0] pc,
                              input logic f, input logic [1:0] bc, input logic [1:0] tc);
        push(tag, r, pc, f, bc, tc);
        check_out();
    endtask

    // Apply the current inputs for one edge, then check the outputs after that edge.
    task automatic step(input string tag, input logic r, input logic [15:0] pc,
                        input logic f, input logic [1:0] bc, input logic [1:0] tc);
        push(tag, r, pc, f, bc, tc);
        @(posedge CLK);
        #1;
        bus.br_valid    = 1'b0;
        bus.clear_stats = 1'b0;
        check_out();
    endtask

    task automatic drive(input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic [5:0] off);
        bus.br_valid = 1'b1;
        bus.br_mode  = mode;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.pc_ex    = pc;
        bus.offset   = off;
    endtask

    initial begin
        bus.br_valid = 1'b0; bus.br_mode = 3'b000; bus.op_a = '0; bus.op_b = '0;
        bus.pc_ex = '0; bus.offset = '0; bus.stall = 1'b0; bus.clear_stats = 1'b0;
        #2;
        expect_now("reset", 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);
        #10 RST = 1'b1;

        // BNE not taken
        drive(3'b001, 16'd3, 16'd3, 16'd2, 6'd0);
        step("bne_nt", 1'b0, 16'h0000, 1'b0, 2'd1, 2'd0);
        // BNE taken, offset +1 skips one instruction
        drive(3'b001, 16'd1, 16'd0, 16'd4, 6'd1);
        step("bne_t", 1'b1, 16'h0006, 1'b1, 2'd2, 2'd1);
        drive(3'b110, 16'd0, 16'd0, 16'd9, 6'd0);        // ignored during flush
        step("bne_t1", 1'b0, 16'h0006, 1'b1, 2'd2, 2'd1);
        step("bne_t2", 1'b0, 16'h0006, 1'b0, 2'd2, 2'd1);
        bus.clear_stats = 1'b1;
        step("clr0", 1'b0, 16'h0006, 1'b0, 2'd0, 2'd0);

        // signed vs unsigned
        drive(3'b010, 16'hFFFF, 16'h0001, 16'h0010, 6'd0);
        step("blt", 1'b1, 16'h0011, 1'b1, 2'd1, 2'd1);
        step("blt1", 1'b0, 16'h0011, 1'b1, 2'd1, 2'd1);
        step("blt2", 1'b0, 16'h0011, 1'b0, 2'd1, 2'd1);
        drive(3'b100, 16'hFFFF, 16'h0001, 16'h0010, 6'd0);
        step("bltu", 1'b0, 16'h0011, 1'b0, 2'd2, 2'd1);
        drive(3'b101, 16'hFFFF, 16'h0001, 16'h0020, 6'd2);
        step("bgeu", 1'b1, 16'h0023, 1'b1, 2'd3, 2'd2);
        step("bgeu1", 1'b0, 16'h0023, 1'b1, 2'd3, 2'd2);
        step("bgeu2", 1'b0, 16'h0023, 1'b0, 2'd3, 2'd2);
        bus.clear_stats = 1'b1;
        step("clr1", 1'b0, 16'h0023, 1'b0, 2'd0, 2'd0);
        drive(3'b111, 16'hFFFF, 16'h0001, 16'h0030, 6'd0);
        step("rsvd", 1'b0, 16'h0023, 1'b0, 2'd1, 2'd0);

        // wrap-around and a negative offset
        drive(3'b110, 16'd0, 16'd5, 16'hFFFF, 6'd1);
        step("wrap", 1'b1, 16'h0001, 1'b1, 2'd2, 2'd1);
        step("wrap1", 1'b0, 16'h0001, 1'b1, 2'd2, 2'd1);
        step("wrap2", 1'b0, 16'h0001, 1'b0, 2'd2, 2'd1);
        drive(3'b110, 16'd7, 16'd7, 16'h0003, 6'b111100);
        step("negoff", 1'b1, 16'h0000, 1'b1, 2'd3, 2'd2);
        step("negoff1", 1'b0, 16'h0000, 1'b1, 2'd3, 2'd2);
        step("negoff2", 1'b0, 16'h0000, 1'b0, 2'd3, 2'd2);
        bus.clear_stats = 1'b1;
        step("clr2", 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);

        // stall inside the flush window: flush stays high for 5 cycles
        drive(3'b110, 16'd0, 16'd0, 16'h0040, 6'd5);
        step("stl", 1'b1, 16'h0046, 1'b1, 2'd1, 2'd1);
        step("stl1", 1'b0, 16'h0046, 1'b1, 2'd1, 2'd1);
        bus.stall = 1'b1;
        step("stl2", 1'b0, 16'h0046, 1'b1, 2'd1, 2'd1);
        step("stl3", 1'b0, 16'h0046, 1'b1, 2'd1, 2'd1);
        drive(3'b110, 16'd0, 16'd0, 16'h0050, 6'd0);   // blocked by stall
        step("stl4", 1'b0, 16'h0046, 1'b1, 2'd1, 2'd1);
        bus.stall = 1'b0;
        step("stl5", 1'b0, 16'h0046, 1'b0, 2'd1, 2'd1);
        bus.stall = 1'b1;
        drive(3'b110, 16'd0, 16'd0, 16'h0050, 6'd0);   // stalled while IDLE
        step("stl_idle", 1'b0, 16'h0046, 1'b0, 2'd1, 2'd1);
        bus.stall = 1'b0;

        // saturation at CountWidth=2
        bus.clear_stats = 1'b1;
        step("clr3", 1'b0, 16'h0046, 1'b0, 2'd0, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            logic [1:0] c;
            c = (i > 3) ? 2'd3 : 2'(i);
            drive(3'b110, 16'd0, 16'd0, 16'(i), 6'd0);
            step("sat", 1'b1, 16'(i + 1), 1'b1, c, c);
            step("sat1", 1'b0, 16'(i + 1), 1'b1, c, c);
            step("sat2", 1'b0, 16'(i + 1), 1'b0, c, c);
        end
        drive(3'b110, 16'd0, 16'd0, 16'h0030, 6'd0);
        bus.clear_stats = 1'b1;
        step("clr_acc", 1'b1, 16'h0031, 1'b1, 2'd0, 2'd0);

        // asynchronous reset during the flush
        #2 RST = 1'b0;
        #1;
        expect_now("async_rst", 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);
        #2 RST = 1'b1;
        drive(3'b001, 16'd1, 16'd2, 16'h0008, 6'h3F);
        step("post_rst", 1'b1, 16'h0008, 1'b1, 2'd1, 2'd1);
        step("post_rst1", 1'b0, 16'h0008, 1'b1, 2'd1, 2'd1);
        step("post_rst2", 1'b0, 16'h0008, 1'b0, 2'd1, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
